pipeline_hazard_controller: RTL and testbench

//  Central stall/flush sequencer for the 5-stage ARM32 pipeline.
//  - Drives sel_stall of the fetch/decode/execute pipeline units and the NOP-insert (flush) of the decode/execute registers.
//  - Detects load-use hazards and resolved taken branches; honours memory wait-states.
//  - Sits beside the controller stages; consumes decoded register fields from the decode and execute units.

---
 rtl/hazard_pkg.sv | 19 +
 rtl/hazard_if.sv | 45 ++++
 rtl/hazard_detect.sv | 20 ++
 rtl/pipeline_hazard_controller.sv | 150 +++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    BR_FLUSH   = 2'd2,
    MEM_WAIT   = 2'd3
  } hz_state_t;

  localparam logic [31:0] NOP_INSTR = 32'hE320F000;
  localparam logic [3:0]  REG_PC    = 4'd15;

  function automatic logic reg_match(input logic en, input logic [3:0] src,
                                     input logic [3:0] dst);
    return en && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_if.sv
// Decode/execute hazard fields in, stall/flush controls out.
// HAZARD_PERF_CNT_EN adds the perf_stall_cnt/perf_flush_cnt signals.
interface hazard_if;
  logic [3:0] dec_rn;
  logic [3:0] dec_rm;
  logic [3:0] dec_rs;
  logic [2:0] dec_use;
  logic       ex_is_load;
  logic [3:0] ex_rd;
  logic       branch_taken;
  logic       mem_busy;
  logic       stall_fetch;
  logic       stall_decode;
  logic       stall_execute;
  logic       flush_decode;
  logic       flush_execute;
  logic       mem_err;
  logic [1:0] state_dbg;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] perf_stall_cnt;
  logic [15:0] perf_flush_cnt;

  modport master (
    output dec_rn, dec_rm, dec_rs, dec_use, ex_is_load, ex_rd, branch_taken, mem_busy,
    input  stall_fetch, stall_decode, stall_execute, flush_decode, flush_execute, mem_err,
    input  state_dbg, perf_stall_cnt, perf_flush_cnt
  );
  modport slave (
    input  dec_rn, dec_rm, dec_rs, dec_use, ex_is_load, ex_rd, branch_taken, mem_busy,
    output stall_fetch, stall_decode, stall_execute, flush_decode, flush_execute, mem_err,
    output state_dbg, perf_stall_cnt, perf_flush_cnt
  );
`else
  modport master (
    output dec_rn, dec_rm, dec_rs, dec_use, ex_is_load, ex_rd, branch_taken, mem_busy,
    input  stall_fetch, stall_decode, stall_execute, flush_decode, flush_execute, mem_err,
    input  state_dbg
  );
  modport slave (
    input  dec_rn, dec_rm, dec_rs, dec_use, ex_is_load, ex_rd, branch_taken, mem_busy,
    output stall_fetch, stall_decode, stall_execute, flush_decode, flush_execute, mem_err,
    output state_dbg
  );
`endif
endinterface

// File: rtl/hazard_detect.sv
// Load-use comparator: decode reads a register the execute-stage LDR is about to write.
module hazard_detect
  import hazard_pkg::*;
(
  input  logic [3:0] dec_rn,
  input  logic [3:0] dec_rm,
  input  logic [3:0] dec_rs,
  input  logic [2:0] dec_use,
  input  logic       ex_is_load,
  input  logic [3:0] ex_rd,
  output logic       hz
);

  always_comb begin
    hz = ex_is_load & (reg_match(dec_use[0], dec_rn, ex_rd) |
                       reg_match(dec_use[1], dec_rm, ex_rd) |
                       reg_match(dec_use[2], dec_rs, ex_rd));
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken branch, memory wait-states.
// Define HAZARD_PERF_CNT_EN to add saturating stall-cycle and branch-flush counters.
module pipeline_hazard_controller
  import hazard_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned MEM_TIMEOUT  = 15
) (
  input logic     clk,
  input logic     rst,
  hazard_if.slave hif
);

  localparam logic [2:0] CntReload = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] WcntMax   = 8'(MEM_TIMEOUT);

  hz_state_t  state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic       hz;
  logic       stall_fetch, stall_decode, stall_execute;
  logic       flush_decode, flush_execute, mem_err;

  hazard_detect u_hazard_detect (
    .dec_rn    (hif.dec_rn),
    .dec_rm    (hif.dec_rm),
    .dec_rs    (hif.dec_rs),
    .dec_use   (hif.dec_use),
    .ex_is_load(hif.ex_is_load),
    .ex_rd     (hif.ex_rd),
    .hz        (hz)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      RUN: begin
        if (hif.mem_busy) begin
          state_d = MEM_WAIT;
          wcnt_d  = '0;
        end else if (hif.branch_taken) begin
          state_d = BR_FLUSH;
          cnt_d   = CntReload;
        end else if (hz) begin
          state_d = LOAD_STALL;
        end
      end
      LOAD_STALL: state_d = RUN;
      // Further taken branches here are wrong-path and already squashed.
      BR_FLUSH: begin
        if (cnt_q == '0) state_d = RUN;
        else             cnt_d   = cnt_q - 3'd1;
      end
      MEM_WAIT: begin
        if (!hif.mem_busy) begin
          state_d = RUN;
          wcnt_d  = '0;
        end else if (wcnt_q == WcntMax) begin
          wcnt_d = '0;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Only RUN looks at live inputs; gated by rst so a held reset yields quiet outputs.
  always_comb begin
    stall_fetch   = 1'b0;
    stall_decode  = 1'b0;
    stall_execute = 1'b0;
    flush_decode  = 1'b0;
    flush_execute = 1'b0;
    mem_err       = 1'b0;
    unique case (state_q)
      RUN: begin
        if (!rst) begin
          if (hif.mem_busy) begin
            stall_fetch   = 1'b1;
            stall_decode  = 1'b1;
            stall_execute = 1'b1;
          end else if (hif.branch_taken) begin
            flush_decode  = 1'b1;
            flush_execute = 1'b1;
          end else if (hz) begin
            stall_fetch   = 1'b1;
            stall_decode  = 1'b1;
            flush_execute = 1'b1;
          end
        end
      end
      LOAD_STALL: ;
      BR_FLUSH: flush_decode = 1'b1;
      MEM_WAIT: begin
        stall_fetch   = 1'b1;
        stall_decode  = 1'b1;
        stall_execute = 1'b1;
        mem_err       = (wcnt_q == WcntMax);
      end
      default: ;
    endcase
  end

  assign hif.stall_fetch   = stall_fetch;
  assign hif.stall_decode  = stall_decode;
  assign hif.stall_execute = stall_execute;
  assign hif.flush_decode  = flush_decode;
  assign hif.flush_execute = flush_execute;
  assign hif.mem_err       = mem_err;
  assign hif.state_dbg     = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] perf_stall_q, perf_flush_q;
  logic        any_stall, flush_evt;

  always_comb begin
    any_stall = stall_fetch | stall_decode | stall_execute;
    flush_evt = (state_q == RUN) && !rst && !hif.mem_busy && hif.branch_taken;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (any_stall && (perf_stall_q != 16'hFFFF)) perf_stall_q <= perf_stall_q + 16'd1;
      if (flush_evt && (perf_flush_q != 16'hFFFF)) perf_flush_q <= perf_flush_q + 16'd1;
    end
  end

  assign hif.perf_stall_cnt = perf_stall_q;
  assign hif.perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: vector table plus multi-cycle sequences.
module tb_pipeline_hazard_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_if hif ();

  pipeline_hazard_controller #(
    .FLUSH_CYCLES(2),
    .MEM_TIMEOUT (15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hif(hif)
  );

  typedef struct packed {
    logic       mb;
    logic       bt;
    logic       ld;
    logic [3:0] rd;
    logic [3:0] rn;
    logic [3:0] rm;
    logic [3:0] rs;
    logic [2:0] ren;
  } in_t;

  typedef struct packed {
    in_t        in;
    logic [7:0] exp;
  } vec_t;

  // {stall_fetch, stall_decode, stall_execute, flush_decode, flush_execute, mem_err, state[1:0]}
  localparam logic [7:0] O_IDLE = 8'b000_00_0_00;
  localparam logic [7:0] O_HZ   = 8'b110_01_0_00;
  localparam logic [7:0] O_LS   = 8'b000_00_0_01;
  localparam logic [7:0] O_BR   = 8'b000_11_0_00;
  localparam logic [7:0] O_BF   = 8'b000_10_0_10;
  localparam logic [7:0] O_MB   = 8'b111_00_0_00;
  localparam logic [7:0] O_MW   = 8'b111_00_0_11;
  localparam logic [7:0] O_ME   = 8'b111_00_1_11;

  vec_t vecs [20];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic in_t mk(input logic mb, input logic bt, input logic ld,
                             input logic [3:0] rd, input logic [3:0] rn,
                             input logic [3:0] rm, input logic [3:0] rs,
                             input logic [2:0] ren);
    in_t v;
    v.mb = mb; v.bt = bt; v.ld = ld; v.rd = rd;
    v.rn = rn; v.rm = rm; v.rs = rs; v.ren = ren;
    return v;
  endfunction

  task automatic apply(input logic r, input in_t v);
    rst              = r;
    hif.mem_busy     = v.mb;
    hif.branch_taken = v.bt;
    hif.ex_is_load   = v.ld;
    hif.ex_rd        = v.rd;
    hif.dec_rn       = v.rn;
    hif.dec_rm       = v.rm;
    hif.dec_rs       = v.rs;
    hif.dec_use      = v.ren;
  endtask

  task automatic check(input string name, input logic [7:0] exp);
    logic [7:0] act;
    act = {hif.stall_fetch, hif.stall_decode, hif.stall_execute,
           hif.flush_decode, hif.flush_execute, hif.mem_err, hif.state_dbg};
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the edge, sample mid-cycle.
  task automatic cyc(input logic r, input in_t v, input string name, input logic [7:0] exp);
    @(posedge clk);
    #1;
    apply(r, v);
    #2;
    check(name, exp);
  endtask

  initial begin
    in_t idle, hz_rm, bri, bm, mbusy;
    idle  = mk(0, 0, 0, 4'd0, 4'd0, 4'd0, 4'd0, 3'b000);
    hz_rm = mk(0, 0, 1, 4'd3, 4'd1, 4'd3, 4'd4, 3'b010);
    bri   = mk(0, 1, 0, 4'd0, 4'd0, 4'd0, 4'd0, 3'b000);
    bm    = mk(1, 1, 0, 4'd0, 4'd0, 4'd0, 4'd0, 3'b000);
    mbusy = mk(1, 0, 0, 4'd0, 4'd0, 4'd0, 4'd0, 3'b000);

    vecs[0]  = '{idle, O_IDLE};
    vecs[1]  = '{mk(0, 0, 1, 4'd3, 4'd1, 4'd2, 4'd4, 3'b111), O_IDLE};
    vecs[2]  = '{mk(0, 0, 1, 4'd3, 4'd1, 4'd3, 4'd4, 3'b101), O_IDLE};
    vecs[3]  = '{hz_rm, O_HZ};
    vecs[4]  = '{hz_rm, O_LS};
    vecs[5]  = '{idle, O_IDLE};
    vecs[6]  = '{mk(0, 0, 1, 4'd7, 4'd7, 4'd0, 4'd0, 3'b001), O_HZ};
    vecs[7]  = '{idle, O_LS};
    vecs[8]  = '{mk(0, 0, 1, 4'd15, 4'd0, 4'd0, 4'd15, 3'b100), O_HZ};
    vecs[9]  = '{idle, O_LS};
    vecs[10] = '{mk(0, 0, 0, 4'd5, 4'd5, 4'd5, 4'd5, 3'b111), O_IDLE};
    vecs[11] = '{mk(0, 1, 1, 4'd3, 4'd1, 4'd3, 4'd4, 3'b010), O_BR};
    vecs[12] = '{bri, O_BF};
    vecs[13] = '{idle, O_BF};
    vecs[14] = '{idle, O_IDLE};
    vecs[15] = '{mk(1, 0, 1, 4'd3, 4'd1, 4'd3, 4'd4, 3'b010), O_MB};
    vecs[16] = '{hz_rm, O_MW};
    vecs[17] = '{hz_rm, O_HZ};
    vecs[18] = '{idle, O_LS};
    vecs[19] = '{idle, O_IDLE};

    // Reset held two cycles with mem_busy and branch_taken asserted.
    apply(1'b1, bm);
    @(posedge clk);
    #3;
    check("rst_hold", O_IDLE);
    cyc(1'b0, idle, "rst_release", O_IDLE);

    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, vecs[i].in, $sformatf("vec%0d", i), vecs[i].exp);
    end

    // mem_busy beats a simultaneous branch; the branch is taken once back in RUN.
    cyc(1'b0, bm, "mb_br_c0", O_MB);
    for (int k = 1; k < 4; k++) cyc(1'b0, bm, $sformatf("mb_br_c%0d", k), O_MW);
    cyc(1'b0, bri, "mb_br_c4", O_MW);
    cyc(1'b0, bri, "mb_br_c5", O_BR);
    cyc(1'b0, idle, "mb_br_c6", O_BF);
    cyc(1'b0, idle, "mb_br_c7", O_BF);
    cyc(1'b0, idle, "mb_br_c8", O_IDLE);

    // Long wait-state: mem_err at cycles 16 and 32.
    for (int k = 0; k < 40; k++) begin
      cyc(1'b0, mbusy, $sformatf("tmo_c%0d", k),
          (k == 0) ? O_MB : ((k == 16 || k == 32) ? O_ME : O_MW));
    end
    cyc(1'b0, idle, "tmo_c40", O_MW);
    cyc(1'b0, idle, "tmo_c41", O_IDLE);

    // Fresh reset, then 3 branches and one load-use.
    cyc(1'b1, idle, "rst2", O_IDLE);
    for (int b = 0; b < 3; b++) begin
      cyc(1'b0, bri, $sformatf("br%0d_c0", b), O_BR);
      cyc(1'b0, idle, $sformatf("br%0d_c1", b), O_BF);
      cyc(1'b0, idle, $sformatf("br%0d_c2", b), O_BF);
    end
    cyc(1'b0, hz_rm, "lu_c0", O_HZ);
    cyc(1'b0, idle, "lu_c1", O_LS);
    cyc(1'b0, idle, "lu_c2", O_IDLE);
`ifdef HAZARD_PERF_CNT_EN
    check16("perf_flush", hif.perf_flush_cnt, 16'd3);
    check16("perf_stall", hif.perf_stall_cnt, 16'd1);
`endif

    // Reset in the first BR_FLUSH cycle leaves no residual bubble.
    cyc(1'b0, bri, "rstbf_c0", O_BR);
    cyc(1'b1, idle, "rstbf_c1", O_BF);
    cyc(1'b0, idle, "rstbf_c2", O_IDLE);
`ifdef HAZARD_PERF_CNT_EN
    check16("perf_flush_rst", hif.perf_flush_cnt, 16'd0);
    check16("perf_stall_rst", hif.perf_stall_cnt, 16'd0);
`endif
    cyc(1'b0, idle, "rstbf_c3", O_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
